// File: rtl/serial_sub_pkg.sv
// Shared types for the digit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Valid/ready operand and result ports of serial_sub.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bor;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, sat, out_ready,
        input  in_ready, out_valid, diff, bor, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, sat, out_ready,
        output in_ready, out_valid, diff, bor, ovf, zero
    );
endinterface

// File: rtl/serial_sub_digit_sub.sv
// Combinational ripple of DIGIT full-subtractor cells; b_top is the borrow into the top bit.
module digit_sub #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             b_top
);
    logic [DIGIT:0] w_brw;

    always_comb begin
        w_brw    = '0;
        d        = '0;
        w_brw[0] = bi;
        for (int i = 0; i < int'(DIGIT); i++) begin
            d[i]       = a_d[i] ^ b_d[i] ^ w_brw[i];
            w_brw[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & w_brw[i]);
        end
    end

    assign bo    = w_brw[DIGIT];
    assign b_top = w_brw[DIGIT-1];
endmodule

// File: rtl/serial_sub.sv
// Digit-serial a - b - bin over WIDTH bits, DIGIT bits per clock, with borrow/overflow/zero flags.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_sub_if.slave    io
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_brw;
    logic             r_sat;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_diff;
    logic             r_bor;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT-1:0] w_d;
    logic             w_bo;
    logic             w_btop;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_final;

    digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
        .a_d   (r_a[DIGIT-1:0]),
        .b_d   (r_b[DIGIT-1:0]),
        .bi    (r_brw),
        .d     (w_d),
        .bo    (w_bo),
        .b_top (w_btop)
    );

    // Result digits enter at the MSB end so the LSB digit lands at bit 0 after NDIG shifts.
    assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));
    assign w_final   = (r_sat && w_bo) ? '0 : w_acc_nxt;
    assign w_last    = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (io.in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (io.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, borrow chain, digit counter and result latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_brw  <= 1'b0;
            r_sat  <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bor  <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io.in_valid) begin
                        r_a   <= io.a;
                        r_b   <= io.b;
                        r_brw <= io.bin;
                        r_sat <= io.sat;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_acc <= w_acc_nxt;
                    r_brw <= w_bo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= w_final;
                        r_bor  <= w_bo;
                        r_ovf  <= w_btop ^ w_bo;
                        r_zero <= (w_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = w_in_ready;
    assign io.out_valid = w_out_valid;
    assign io.diff      = r_diff;
    assign io.bor       = r_bor;
    assign io.ovf       = r_ovf;
    assign io.zero      = r_zero;
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=8 with DIGIT=4, 1 and 8 instances run side by side.
module tb_serial_sub;
    logic       clk;
    logic       rst_n;
    logic       iv4;
    logic       ivx;
    logic       rdy4;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       bin_s;
    logic       sat_s;

    int n_chk  = 0;
    int n_fail = 0;

    serial_sub_if #(.WIDTH(8)) if4 ();
    serial_sub_if #(.WIDTH(8)) if1 ();
    serial_sub_if #(.WIDTH(8)) if8 ();

    assign if4.in_valid = iv4;
    assign if1.in_valid = ivx;
    assign if8.in_valid = ivx;
    assign if4.out_ready = rdy4;
    assign if1.out_ready = 1'b1;
    assign if8.out_ready = 1'b1;
    assign if4.a = a_s;  assign if1.a = a_s;  assign if8.a = a_s;
    assign if4.b = b_s;  assign if1.b = b_s;  assign if8.b = b_s;
    assign if4.bin = bin_s; assign if1.bin = bin_s; assign if8.bin = bin_s;
    assign if4.sat = sat_s; assign if1.sat = sat_s; assign if8.sat = sat_s;

    serial_sub #(.WIDTH(8), .DIGIT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(if4));
    serial_sub #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io(if1));
    serial_sub #(.WIDTH(8), .DIGIT(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One operation on all three instances; results captured on each first out_valid cycle.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input logic st, input logic [7:0] e_diff,
                          input logic e_bor, input logic e_ovf, input logic e_zero);
        logic [7:0] d4, d1, d8;
        logic [2:0] f4, f1, f8;
        int lat4, lat1, lat8;
        lat4 = 0; lat1 = 0; lat8 = 0;
        d4 = '0; d1 = '0; d8 = '0; f4 = '0; f1 = '0; f8 = '0;
        @(negedge clk);
        iv4 = 1'b1; ivx = 1'b1; a_s = a; b_s = b; bin_s = bi; sat_s = st;
        @(posedge clk);
        #1 iv4 = 1'b0; ivx = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (if4.out_valid && lat4 == 0) begin
                lat4 = c; d4 = if4.diff; f4 = {if4.bor, if4.ovf, if4.zero};
            end
            if (if1.out_valid && lat1 == 0) begin
                lat1 = c; d1 = if1.diff; f1 = {if1.bor, if1.ovf, if1.zero};
            end
            if (if8.out_valid && lat8 == 0) begin
                lat8 = c; d8 = if8.diff; f8 = {if8.bor, if8.ovf, if8.zero};
            end
        end
        chk({tag, "_d4_diff"},  32'(d4), 32'(e_diff));
        chk({tag, "_d4_flags"}, 32'(f4), 32'({e_bor, e_ovf, e_zero}));
        chk({tag, "_d4_lat"},   32'(lat4), 32'd3);
        chk({tag, "_d1_diff"},  32'(d1), 32'(e_diff));
        chk({tag, "_d1_flags"}, 32'(f1), 32'({e_bor, e_ovf, e_zero}));
        chk({tag, "_d1_lat"},   32'(lat1), 32'd9);
        chk({tag, "_d8_diff"},  32'(d8), 32'(e_diff));
        chk({tag, "_d8_flags"}, 32'(f8), 32'({e_bor, e_ovf, e_zero}));
        chk({tag, "_d8_lat"},   32'(lat8), 32'd2);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; iv4 = 1'b0; ivx = 1'b0; rdy4 = 1'b1;
        a_s = '0; b_s = '0; bin_s = 1'b0; sat_s = 1'b0;
        #12;
        chk("rst_in_ready", 32'(if4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
        chk("rst_diff", 32'(if4.diff), 32'd0);
        chk("rst_flags", 32'({if4.bor, if4.ovf, if4.zero}), 32'd0);
        chk("rst_rdy_others", 32'({if1.in_ready, if8.in_ready}), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",   8'h35, 8'h12, 1'b0, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0);
        run_op("uflow",   8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("uflow_s", 8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        run_op("rip",     8'h10, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("bin_sat", 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

        // Back-pressure: hold the result while new operands are driven at the port.
        rdy4 = 1'b0;
        @(negedge clk);
        iv4 = 1'b1; a_s = 8'h35; b_s = 8'h12; bin_s = 1'b0; sat_s = 1'b0;
        @(posedge clk);
        #1 iv4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = if4.out_valid;
        end
        chk("bp_reach_done", 32'(seen), 32'd1);
        for (int c = 0; c < 5; c++) begin
            iv4 = ~iv4; a_s = 8'hA0 + 8'(c); b_s = 8'h0C; bin_s = 1'b1; sat_s = 1'b1;
            @(negedge clk);
            chk("bp_diff", 32'(if4.diff), 32'h23);
            chk("bp_flags", 32'({if4.bor, if4.ovf, if4.zero}), 32'd0);
            chk("bp_hs", 32'({if4.in_ready, if4.out_valid}), 32'b01);
        end
        rdy4 = 1'b1; iv4 = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'({if4.in_ready, if4.out_valid}), 32'b10);
        iv4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if4.out_valid || !if4.in_ready) seen = 1'b1;
        end
        chk("bp_no_capture", 32'(seen), 32'd0);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        iv4 = 1'b1; a_s = 8'h80; b_s = 8'h01;
        @(posedge clk);
        #1 iv4 = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(if4.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", 32'({if4.in_ready, if4.out_valid}), 32'b10);
        chk("mid_rst_diff", 32'(if4.diff), 32'd0);
        chk("mid_rst_flags", 32'({if4.bor, if4.ovf, if4.zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if4.out_valid) seen = 1'b1;
        end
        chk("post_rst_no_valid", 32'(seen), 32'd0);
        run_op("after_rst", 8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
# serial_sub

Parametrised digit-serial subtractor: computes `a - b - bin` over WIDTH bits, DIGIT bits per clock, using a registered borrow chain. Reports borrow-out, signed overflow and zero flags, with an optional unsigned-saturation mode. It is the sequential, wide-operand successor to the single-bit full-subtractor cell. It sits behind a valid/ready input port and a valid/ready output port, so it drops into the datapath wherever area matters more than latency.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- sat  in  1  1 = clamp unsigned underflow to 0; 0 = wrap.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- diff  out  WIDTH  result.
- bor  out  1  unsigned borrow-out of full-width subtract, before saturation.
- ovf  out  1  signed (two's-complement) overflow of `a - b - bin`.
- zero  out  1  diff (after saturation) == 0.

## Operation
- NDIG = WIDTH/DIGIT.
- FSM states:
  - IDLE: `in_ready = 1`. On `in_valid`, capture a, b, bin, sat into shift registers and the borrow register, clear the digit counter, then go to RUN.
  - RUN: each cycle, subtract digit i (LSB digit first) with the registered borrow. Shift the result digit into the diff register and register the new borrow. After digit NDIG-1, go to DONE.
  - DONE: `out_valid = 1`. On `out_ready`, go to IDLE.
- At the last RUN cycle:
  - `bor` = final borrow.
  - `ovf` = borrow into the MSB XOR borrow out of the MSB.
  - If `sat && bor`, diff is forced to 0.
  - `zero` is computed on the final diff.
- All result fields are latched on entry to DONE and held stable while `out_valid && !out_ready`.
- in_ready is decoded from `state == IDLE` only. Inputs presented outside IDLE are ignored and are not queued.
- Arithmetic is modulo 2^WIDTH. The borrow chain never drops a bit between digits.

## Timing
- Reset, asynchronous while `rst_n = 0`:
  - state = IDLE, counter = 0, borrow register = 0.
  - diff = 0, bor = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready = 1.
- Accept edge T (`in_valid && in_ready`): RUN covers cycles T+1 … T+NDIG, and out_valid is high from T+NDIG+1.
- Latency, accept to out_valid: NDIG+1 cycles. Best-case throughput: one operation per NDIG+2 cycles.
- The output transfer edge returns the FSM to IDLE; in_ready is high on the following cycle. Accepting new input in the same cycle as the output transfer is not allowed.
- `DIGIT = WIDTH`: NDIG = 1, and a single RUN cycle gives latency 2.
- Reset mid-RUN or mid-DONE: the operation is aborted, no out_valid is produced, and all outputs take their reset values.
- `out_ready` held high while in IDLE/RUN has no effect.

## Structure
- Package serial_sub_pkg holds the state enum typedef (IDLE, RUN, DONE) and the state encoding constants.
- Sub-module digit_sub (parameter DIGIT) is a combinational ripple of DIGIT full-subtractor cells:
  - inputs: a_d, b_d, bi.
  - outputs: d, bo, and b_top (borrow into the top bit, used for ovf).
- The top level contains the FSM, operand shift registers, digit counter ($clog2(NDIG+1) bits), borrow register and output registers.

## Test plan
Run at WIDTH=8, DIGIT=4, plus a regression at DIGIT=1 and DIGIT=8.
- a=0x35, b=0x12, bin=0, sat=0 accepted at T → out_valid at T+3 with diff=0x23, bor=0, ovf=0, zero=0.
- Underflow, a=0x00, b=0x01, bin=0:
  - sat=0 → diff=0xFF, bor=1, zero=0.
  - sat=1 → diff=0x00, bor=1, zero=1.
- a=0x80, b=0x01 → diff=0x7F, bor=0, ovf=1. Also a=0x7F, b=0xFF → diff=0x80, bor=1, ovf=1.
- a=0x10, b=0x0F, bin=1 (borrow ripples across the digit boundary) → diff=0x00, zero=1, bor=0.
- Back-pressure: out_ready held low for 5 cycles in DONE, with in_valid toggling and new operands driven → diff/flags stable, in_ready=0, and none of those operands are captured. out_ready=1 → in_ready=1 on the next cycle.
- rst_n pulsed low during RUN → outputs zero immediately, in_ready=1, and no out_valid appears. A subsequent operation completes correctly.
